fft_bar_scaler: RTL and testbench
=================================

Name: fft_bar_scaler

Overview:
- Consumes FFT output samples (two complex bins per cycle, each with its own bin address) and converts each to a log-scaled bar height for the VGA stage.
- Sits between the FFT block and the VGA block.
- Writes heights into a ping-pong bar memory: 2 banks of 512 x 9-bit registers.
- The VGA side reads one bank while the FFT side fills the other; banks swap on frame completion.

Parameters:
FRAC_BITS, 3, fractional mantissa bits kept below the leading one in the log code
LOG_FLOOR, 64, log code subtracted before scaling (noise floor; 64 = magnitude 2^8)
GAIN_SHIFT, 1, left shift applied to the floored code
HEIGHT_MAX, 479, saturation ceiling for bar height
DECAY_STEP, 4, per-frame bar fall in pixels (only with PEAK_DECAY_EN)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous active-high reset
sample_valid_i  in  1  both sample lanes valid this cycle
fft_done_i  in  1  one-cycle pulse, frame complete; may coincide with the last sample_valid_i
addr1_i  in  10  bin address, lane 1
addr2_i  in  10  bin address, lane 2
real1_i  in  32  signed real part, lane 1
img1_i  in  32  signed imaginary part, lane 1
real2_i  in  32  signed real part, lane 2
img2_i  in  32  signed imaginary part, lane 2
rd_addr_i  in  9  VGA read bin (0..511)
rd_data_o  out  9  bar height of rd_addr_i in the display bank; 1-cycle latency
frame_ready_o  out  1  one-cycle pulse when the display bank swaps
disp_bank_o  out  1  bank currently shown to VGA

Behaviour:
- Reset state (asynchronous, active-high):
  - rd_data_o=0, frame_ready_o=0, disp_bank_o=0.
  - Write-entry bank wr_bank=1.
  - All pipeline valid/marker bits 0.
  - Both banks cleared to 0.
- Reset mid-frame discards all in-flight samples and markers.
- Pipeline: 3 register stages per lane, identical lanes; each stage carries {valid, addr, bank tag}.
- S1, absolute value:
  - |x| computed for real and imaginary parts.
  - -2^31 saturates to 2^31-1.
  - Bank tag = wr_bank at entry.
- S2, magnitude:
  - mag = max(|re|,|im|) + (min(|re|,|im|) >> 1).
  - 33-bit unsigned, no overflow.
- S3, log encode:
  - If mag=0, code=0.
  - Otherwise p = index of leading one (0..32) and f = next FRAC_BITS bits below it, zero-padded when p<FRAC_BITS.
  - code = p*2^FRAC_BITS + f.
  - h = min(HEIGHT_MAX, max(0, code-LOG_FLOOR) << GAIN_SHIFT).
- Write-back on the cycle after S3: bank[tag][addr[8:0]] <= h.
  - Only when valid and addr[9]=0; upper bins are mirror images and are dropped.
  - Latency: sample_valid_i at cycle T -> memory updated at the end of T+3.
  - Both lanes at the same address in the same cycle: lane 2 wins.
- Frame handshake:
  - fft_done_i toggles wr_bank at the end of the same cycle, so samples presented with fft_done_i keep the old tag.
  - A marker enters the pipeline with fft_done_i.
  - When the marker leaves S3 (T+3): frame_ready_o=1 for one cycle, and disp_bank_o <= the tag of the just-finished bank, effective the next cycle.
  - The write for that last sample lands in the same cycle.
- fft_done_i while a previous marker is still in flight: each marker is handled independently, in order.
- Read port:
  - rd_data_o <= bank[disp_bank_o][rd_addr_i], registered.
  - A read in the swap cycle returns the old bank.
  - A read-during-write to the display bank (only possible on overlap) returns the old value.

Optional Feature:
PEAK_DECAY_EN
- Defined: at write-back, stored = max(h, prev - DECAY_STEP, saturating at 0).
  - prev = same bin in the other bank (last displayed frame).
  - Gives falling-bar peak hold.
- Undefined: stored = h. No reads of the other bank; DECAY_STEP is unused.

Test Plan:
- After reset, read bins 0..511 -> rd_data_o=0, disp_bank_o=0, frame_ready_o=0.
- Lane 1 addr=5, re=4096, im=0 -> code 96, bank1[5]=64. Then fft_done_i -> frame_ready_o 3 cycles later, disp_bank_o=1, read addr 5 -> 64.
- Lane 1 re=-4096, im=4096 (mag 6144, code 100) -> height 72. Lane 2 re=im=-2^31 (mag 3*2^30-2, code 251) -> height 374.
- Magnitude handling:
  - re=256, im=0 -> 0 (floor).
  - re=im=0 -> 0.
  - addr=600 -> no write anywhere.
  - addr1=addr2=7 with different values -> lane 2 value stored.
- Last sample and fft_done_i in the same cycle -> sample in the finished bank; the next frame's samples go to the other bank; assert rst mid-frame -> all outputs and memory 0 immediately.
- PEAK_DECAY_EN: frame A bin 3=100, frame B bin 3=0 -> 96, frame C -> 92; frame D h=200 -> 200.

Source files
------------

// File: rtl/fft_bar_scaler_if.sv
// fft_bar_scaler_if: FFT sample lanes, frame handshake and VGA read port of fft_bar_scaler
interface fft_bar_scaler_if;
    logic        sample_valid_i;
    logic        fft_done_i;
    logic [9:0]  addr1_i;
    logic [9:0]  addr2_i;
    logic [31:0] real1_i;
    logic [31:0] img1_i;
    logic [31:0] real2_i;
    logic [31:0] img2_i;
    logic [8:0]  rd_addr_i;
    logic [8:0]  rd_data_o;
    logic        frame_ready_o;
    logic        disp_bank_o;
    modport slave (
        input  sample_valid_i, fft_done_i, addr1_i, addr2_i, real1_i, img1_i, real2_i, img2_i, rd_addr_i,
        output rd_data_o, frame_ready_o, disp_bank_o
    );
    modport master (
        output sample_valid_i, fft_done_i, addr1_i, addr2_i, real1_i, img1_i, real2_i, img2_i, rd_addr_i,
        input  rd_data_o, frame_ready_o, disp_bank_o
    );
endinterface

// File: rtl/fft_bar_scaler.sv
// fft_bar_scaler: FFT bins -> log-scaled bar heights in a ping-pong bar memory; define PEAK_DECAY_EN for falling-bar peak hold
module fft_bar_scaler #(
    parameter int FRAC_BITS  = 3,
    parameter int LOG_FLOOR  = 64,
    parameter int GAIN_SHIFT = 1,
    parameter int HEIGHT_MAX = 479,
    parameter int DECAY_STEP = 4
) (
    input logic             clk,
    input logic             rst,
    fft_bar_scaler_if.slave bus
);
    logic [9:0]  a_in [2];
    logic [31:0] re_in [2];
    logic [31:0] im_in [2];
    logic [2:0]  v_q [2];
    logic [2:0]  v_d [2];
    logic [2:0]  t_q [2];
    logic [2:0]  t_d [2];
    logic [9:0]  a_q [2][3];
    logic [9:0]  a_d [2][3];
    logic [31:0] re_q [2];
    logic [31:0] re_d [2];
    logic [31:0] im_q [2];
    logic [31:0] im_d [2];
    logic [32:0] mag_q [2];
    logic [32:0] mag_d [2];
    logic [8:0]  h_q [2];
    logic [8:0]  h_d [2];
    logic [8:0]  wr_data [2];
    logic [2:0]  m_q, m_d, mt_q, mt_d;
    logic        wr_bank_q, wr_bank_d, disp_bank_q, disp_bank_d;
    logic [8:0]  rd_data_q, rd_data_d;
    logic [8:0]  bank_q [2][512];
`ifdef PEAK_DECAY_EN
    logic [8:0]  prev [2];
    logic [8:0]  dec [2];
`else
    logic [31:0] decay_unused;
    assign decay_unused = DECAY_STEP;
`endif

    function automatic logic [31:0] abs32(input logic [31:0] x);
        return !x[31] ? x : (x == 32'h8000_0000) ? 32'h7fff_ffff : 32'(-x);
    endfunction

    // Leading-one position plus FRAC_BITS mantissa bits, floored, gained and clamped
    function automatic logic [8:0] height(input logic [32:0] m);
        int p, code, fl;
        logic [32:0] s;
        p = 0;
        for (int i = 0; i < 33; i++) if (m[i]) p = i;
        s = m << (32 - p);
        code = (m == '0) ? 0 : p * (1 << FRAC_BITS) + int'(s[31 -: FRAC_BITS]);
        fl = (code > LOG_FLOOR) ? (code - LOG_FLOOR) << GAIN_SHIFT : 0;
        return 9'((fl > HEIGHT_MAX) ? HEIGHT_MAX : fl);
    endfunction

    assign a_in[0]  = bus.addr1_i;
    assign a_in[1]  = bus.addr2_i;
    assign re_in[0] = bus.real1_i;
    assign re_in[1] = bus.real2_i;
    assign im_in[0] = bus.img1_i;
    assign im_in[1] = bus.img2_i;

    always_comb begin
        wr_bank_d   = bus.fft_done_i ? ~wr_bank_q : wr_bank_q;
        m_d         = {m_q[1:0], bus.fft_done_i};
        mt_d        = {mt_q[1:0], wr_bank_q};
        disp_bank_d = m_q[2] ? mt_q[2] : disp_bank_q;
        rd_data_d   = bank_q[disp_bank_q][bus.rd_addr_i];
        for (int l = 0; l < 2; l++) begin
            v_d[l]    = {v_q[l][1:0], bus.sample_valid_i};
            t_d[l]    = {t_q[l][1:0], wr_bank_q};
            a_d[l][0] = a_in[l];
            a_d[l][1] = a_q[l][0];
            a_d[l][2] = a_q[l][1];
            re_d[l]   = abs32(re_in[l]);
            im_d[l]   = abs32(im_in[l]);
            mag_d[l]  = (re_q[l] > im_q[l]) ? {1'b0, re_q[l]} + {2'b0, im_q[l][31:1]}
                                            : {1'b0, im_q[l]} + {2'b0, re_q[l][31:1]};
            h_d[l]    = height(mag_q[l]);
`ifdef PEAK_DECAY_EN
            prev[l]    = bank_q[~t_q[l][2]][a_q[l][2][8:0]];
            dec[l]     = (prev[l] > 9'(DECAY_STEP)) ? prev[l] - 9'(DECAY_STEP) : 9'd0;
            wr_data[l] = (h_q[l] > dec[l]) ? h_q[l] : dec[l];
`else
            wr_data[l] = h_q[l];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q         <= '{default: '0};
            t_q         <= '{default: '0};
            m_q         <= '0;
            mt_q        <= '0;
            wr_bank_q   <= 1'b1;
            disp_bank_q <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            v_q         <= v_d;
            t_q         <= t_d;
            m_q         <= m_d;
            mt_q        <= mt_d;
            wr_bank_q   <= wr_bank_d;
            disp_bank_q <= disp_bank_d;
            rd_data_q   <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q   <= a_d;
        re_q  <= re_d;
        im_q  <= im_d;
        mag_q <= mag_d;
        h_q   <= h_d;
    end

    // Lane 2 is written last so it wins on an address collision; upper mirror bins are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < 512; i++) bank_q[b][i] <= '0;
        end else begin
            for (int l = 0; l < 2; l++)
                if (v_q[l][2] && !a_q[l][2][9]) bank_q[t_q[l][2]][a_q[l][2][8:0]] <= wr_data[l];
        end
    end

    assign bus.rd_data_o     = rd_data_q;
    assign bus.frame_ready_o = m_q[2];
    assign bus.disp_bank_o   = disp_bank_q;
endmodule

// File: tb/tb_fft_bar_scaler.sv
// tb_fft_bar_scaler: directed scoreboard bench for fft_bar_scaler (PEAK_DECAY_EN vectors run when the macro is defined)
module tb_fft_bar_scaler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rd_en = 1'b0;
    logic rd_seen;
    int checks = 0, errors = 0, cyc = 0;
    int pend = 0, pend_bank = 0;
    bit wb = 1'b1;
    int rd_exp_q[$], rd_addr_q[$], fr_cyc_q[$], fr_bank_q[$];

    fft_bar_scaler_if bus();
    fft_bar_scaler dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or posedge rst) rd_seen <= rst ? 1'b0 : rd_en;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rd_seen) begin
            if (rd_exp_q.size() == 0) chk("rd_unexpected", 1, 0);
            else chk($sformatf("rd_data[%0d]", rd_addr_q.pop_front()), int'(bus.rd_data_o), rd_exp_q.pop_front());
        end
        if (pend != 0) begin
            chk("disp_bank_after_swap", int'(bus.disp_bank_o), pend_bank);
            pend = 0;
        end
        if (bus.frame_ready_o) begin
            if (fr_cyc_q.size() == 0) chk("frame_ready_spurious", 1, 0);
            else begin
                chk("frame_ready_cycle", cyc, fr_cyc_q.pop_front());
                pend_bank = fr_bank_q.pop_front();
                pend = 1;
            end
        end
    end

    task automatic clr();
        bus.sample_valid_i = 1'b0;
        bus.fft_done_i     = 1'b0;
        bus.addr1_i        = '0;
        bus.addr2_i        = '0;
        bus.real1_i        = '0;
        bus.img1_i         = '0;
        bus.real2_i        = '0;
        bus.img2_i         = '0;
        bus.rd_addr_i      = '0;
        rd_en              = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            clr();
        end
    endtask

    task automatic smp(input bit done, input logic [9:0] a1, input logic [31:0] r1, input logic [31:0] i1,
                       input logic [9:0] a2, input logic [31:0] r2, input logic [31:0] i2);
        @(negedge clk);
        clr();
        bus.sample_valid_i = 1'b1;
        bus.fft_done_i     = done;
        bus.addr1_i        = a1;
        bus.real1_i        = r1;
        bus.img1_i         = i1;
        bus.addr2_i        = a2;
        bus.real2_i        = r2;
        bus.img2_i         = i2;
        if (done) begin
            fr_cyc_q.push_back(cyc + 3);
            fr_bank_q.push_back(int'(wb));
            wb = ~wb;
        end
    endtask

    task automatic rd(input int a, input int e);
        @(negedge clk);
        clr();
        rd_en         = 1'b1;
        bus.rd_addr_i = 9'(a);
        rd_addr_q.push_back(a);
        rd_exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        clr();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rd_data", int'(bus.rd_data_o), 0);
        chk("rst_disp_bank", int'(bus.disp_bank_o), 0);
        chk("rst_frame_ready", int'(bus.frame_ready_o), 0);
        rst = 1'b0;
        for (int i = 0; i < 512; i++) rd(i, 0);
        // Frame into bank 1; last sample carries fft_done_i
        smp(0, 10'd5, 32'd4096, 32'd0, 10'd1023, 32'd999, 32'd5);
        smp(0, 10'd10, -32'sd4096, 32'd4096, 10'd11, 32'h8000_0000, 32'h8000_0000);
        smp(0, 10'd20, 32'd256, 32'd0, 10'd21, 32'd0, 32'd0);
        smp(0, 10'd600, 32'd1048576, 32'd0, 10'd1023, 32'd1048576, 32'd0);
        smp(0, 10'd7, 32'd4096, 32'd0, 10'd7, -32'sd4096, 32'd4096);
        smp(1, 10'd30, 32'd4096, 32'd0, 10'd31, 32'd1048576, 32'd0);
        idle(4);
        rd(5, 64);
        rd(10, 72);
        rd(11, 374);
        rd(20, 0);
        rd(21, 0);
        rd(88, 0);
        rd(7, 72);
        rd(30, 64);
        rd(31, 192);
        // Frame into bank 0
        smp(1, 10'd5, 32'd65536, 32'd0, 10'd1023, 32'd0, 32'd0);
        idle(4);
        rd(5, 128);
        rd(88, 0);
        rd(30, 0);
        rd(7, 0);
        // Two markers in flight back to back
        smp(1, 10'd40, 32'd4096, 32'd0, 10'd1023, 32'd0, 32'd0);
        smp(1, 10'd41, 32'd4096, 32'd0, 10'd1023, 32'd0, 32'd0);
        idle(5);
        rd(41, 64);
        rd(40, 0);
        rd(5, 128);
        // Read issued in the swap cycle sees the old bank
        smp(1, 10'd50, 32'd4096, 32'd0, 10'd1023, 32'd0, 32'd0);
        idle(2);
        rd(41, 64);
        rd(41, 0);
        rd(50, 64);
        idle(2);
        // Reset mid-frame with a sample and marker in flight
        smp(0, 10'd60, 32'd4096, 32'd0, 10'd1023, 32'd0, 32'd0);
        bus.fft_done_i = 1'b1;
        bus.rd_addr_i  = 9'd50;
        @(negedge clk);
        bus.sample_valid_i = 1'b0;
        bus.fft_done_i     = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_rd_data", int'(bus.rd_data_o), 0);
        chk("midrst_disp_bank", int'(bus.disp_bank_o), 0);
        chk("midrst_frame_ready", int'(bus.frame_ready_o), 0);
        idle(2);
        rst = 1'b0;
        wb = 1'b1;
        rd(50, 0);
        rd(60, 0);
        smp(1, 10'd61, 32'd4096, 32'd0, 10'd1023, 32'd0, 32'd0);
        idle(4);
        rd(61, 64);
        rd(50, 0);
        rd(60, 0);
`ifdef PEAK_DECAY_EN
        smp(1, 10'd3, 32'd20480, 32'd0, 10'd1023, 32'd0, 32'd0);
        idle(4);
        rd(3, 100);
        smp(1, 10'd3, 32'd0, 32'd0, 10'd1023, 32'd0, 32'd0);
        idle(4);
        rd(3, 96);
        smp(1, 10'd3, 32'd0, 32'd0, 10'd1023, 32'd0, 32'd0);
        idle(4);
        rd(3, 92);
        smp(1, 10'd3, 32'd1572864, 32'd0, 10'd1023, 32'd0, 32'd0);
        idle(4);
        rd(3, 200);
`endif
        idle(5);
        chk("rd_queue_drained", rd_exp_q.size(), 0);
        chk("frame_queue_drained", fr_cyc_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
